// File: rtl/athos_pkg.sv
// Shared ATHOS types: FU operand/result records and the FU arbiter state encoding.
package athos_pkg;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } in_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
  } out_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_e;

  // Wide enough for the largest supported FU latency (15).
  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/athos_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo NUM_REQ.
module athos_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // One spare bit holds last_grant + i before the wrap.
  localparam int CW = IDX_W + 1;

  logic          found;
  logic [CW-1:0] cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IDX_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = found && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/athos_fu_arbiter.sv
// Shares one ATHOS FU among NUM_REQ requesters, one operation in flight at a time.
// Optional ATHOS_FU_ARB_STALL_CNT_EN adds a saturating 32-bit stall counter output.
module athos_fu_arbiter
  import athos_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FU_LATENCY = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_valid_i,
  output logic [NUM_REQ-1:0] req_ready_o,
  input  in_t  [NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  input  logic [NUM_REQ-1:0] rsp_ready_i,
  output out_t               rsp_data_o,
  output logic               fu_valid_o,
  output in_t                fu_in_o,
  input  out_t               fu_out_i,
  output logic               busy_o
`ifdef ATHOS_FU_ARB_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e           state_reg, state_next;
  logic [IDX_W-1:0]     owner_reg, last_grant_reg, grant_idx;
  logic [LAT_CNT_W-1:0] cnt_reg;
  in_t                  operand_reg;
  out_t                 result_reg;
  logic [NUM_REQ-1:0]   grant;
  logic                 any_req, accept;

  assign any_req = |req_valid_i;
  assign accept  = (state_reg == IDLE) && any_req;

  athos_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid_i),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (any_req) state_next = EXEC;
      EXEC:    if (cnt_reg == LAT_CNT_W'(1)) state_next = RESP;
      RESP:    if (rsp_ready_i[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant is masked during reset so no handshake can complete on a reset edge.
  always_comb begin
    req_ready_o = '0;
    fu_valid_o  = 1'b0;
    fu_in_o     = '0;
    busy_o      = (state_reg != IDLE);
    if (state_reg == IDLE && !rst_i) req_ready_o = grant;
    if (state_reg == EXEC) begin
      fu_valid_o = 1'b1;
      fu_in_o    = operand_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_valid_o[gi] = (state_reg == RESP) && (owner_reg == IDX_W'(gi));
  end

  assign rsp_data_o = result_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      operand_reg    <= '0;
      result_reg     <= '0;
      owner_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      cnt_reg        <= '0;
    end else begin
      if (accept) begin
        operand_reg    <= req_data_i[grant_idx];
        owner_reg      <= grant_idx;
        last_grant_reg <= grant_idx;
        cnt_reg        <= LAT_CNT_W'(FU_LATENCY);
      end
      if (state_reg == EXEC) begin
        cnt_reg <= cnt_reg - LAT_CNT_W'(1);
        if (cnt_reg == LAT_CNT_W'(1)) result_reg <= fu_out_i;
      end
    end
  end

`ifdef ATHOS_FU_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
    end else if (any_req && (req_ready_o == '0) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule
